// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: one-hot bit indices, opcodes and funct3 values.
// The matching decoder uses the same indices.
package instr_encoder_pkg;

    localparam int unsigned OP_WIDTH     = 9;
    localparam int unsigned BR_FUN_WIDTH = 6;
    localparam int unsigned LD_FUN_WIDTH = 5;
    localparam int unsigned ST_FUN_WIDTH = 3;

    localparam int unsigned OP_LUI    = 0;
    localparam int unsigned OP_AUIPC  = 1;
    localparam int unsigned OP_JAL    = 2;
    localparam int unsigned OP_JALR   = 3;
    localparam int unsigned OP_BRANCH = 4;
    localparam int unsigned OP_LOAD   = 5;
    localparam int unsigned OP_STORE  = 6;
    localparam int unsigned OP_ALU_I  = 7;
    localparam int unsigned OP_ALU_R  = 8;

    localparam int unsigned BR_BEQ  = 0;
    localparam int unsigned BR_BNE  = 1;
    localparam int unsigned BR_BLT  = 2;
    localparam int unsigned BR_BGE  = 3;
    localparam int unsigned BR_BLTU = 4;
    localparam int unsigned BR_BGEU = 5;

    localparam int unsigned LD_LB  = 0;
    localparam int unsigned LD_LH  = 1;
    localparam int unsigned LD_LW  = 2;
    localparam int unsigned LD_LBU = 3;
    localparam int unsigned LD_LHU = 4;

    localparam int unsigned ST_SB = 0;
    localparam int unsigned ST_SH = 1;
    localparam int unsigned ST_SW = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
    localparam logic [6:0] OPC_ALU_R  = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    // Zero-extend narrower one-hot vectors into the 16-bit argument.
    function automatic logic is_onehot16(logic [15:0] v);
        return (v != 16'h0) && ((v & (v - 16'h1)) == 16'h0);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO with full/empty flags; head is presented as zero while empty.
module instr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Assembles RV32I instruction words from decoded fields, rejects illegal requests,
// and buffers legal words in a small output FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [OP_WIDTH-1:0]     op_info_i,
    input  logic [BR_FUN_WIDTH-1:0] br_fun_i,
    input  logic [LD_FUN_WIDTH-1:0] ld_fun_i,
    input  logic [ST_FUN_WIDTH-1:0] st_fun_i,
    input  logic [2:0]              alu_fun3_i,
    input  logic [6:0]              alu_fun7_i,
    input  logic                    ebreak_i,
    input  logic [4:0]              rs1_i,
    input  logic [4:0]              rs2_i,
    input  logic [4:0]              rd_i,
    input  logic [XLEN-1:0]         imm_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [31:0]             out_instr_o,
    output logic                    err_o,
    output logic [7:0]              err_cnt_o
);

    logic        fifo_full, fifo_empty;
    logic        accept, push, bad;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic [2:0]  br_f3, ld_f3, st_f3;
    logic        i_ok, b_ok, j_ok, u_ok, shamt_ok, is_shift;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Upper bits all-equal means the value is the sign-extension of the bits below.
    assign i_ok     = (&imm_i[XLEN-1:11]) | ~(|imm_i[XLEN-1:11]);
    assign b_ok     = ~imm_i[0] & ((&imm_i[XLEN-1:12]) | ~(|imm_i[XLEN-1:12]));
    assign j_ok     = ~imm_i[0] & ((&imm_i[XLEN-1:20]) | ~(|imm_i[XLEN-1:20]));
    assign u_ok     = ~(|imm_i[11:0]) & ((&imm_i[XLEN-1:31]) | ~(|imm_i[XLEN-1:31]));
    assign shamt_ok = ~(|imm_i[XLEN-1:5]);
    assign is_shift = (alu_fun3_i == 3'b001) || (alu_fun3_i == 3'b101);

    always_comb begin
        br_f3 = F3_BEQ;
        if (br_fun_i[BR_BNE])       br_f3 = F3_BNE;
        else if (br_fun_i[BR_BLT])  br_f3 = F3_BLT;
        else if (br_fun_i[BR_BGE])  br_f3 = F3_BGE;
        else if (br_fun_i[BR_BLTU]) br_f3 = F3_BLTU;
        else if (br_fun_i[BR_BGEU]) br_f3 = F3_BGEU;

        ld_f3 = F3_LB;
        if (ld_fun_i[LD_LH])       ld_f3 = F3_LH;
        else if (ld_fun_i[LD_LW])  ld_f3 = F3_LW;
        else if (ld_fun_i[LD_LBU]) ld_f3 = F3_LBU;
        else if (ld_fun_i[LD_LHU]) ld_f3 = F3_LHU;

        st_f3 = F3_SB;
        if (st_fun_i[ST_SH])      st_f3 = F3_SH;
        else if (st_fun_i[ST_SW]) st_f3 = F3_SW;
    end

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        if (ebreak_i) begin
            enc_word  = EBREAK_WORD;
            enc_legal = (op_info_i == '0);
        end else if (is_onehot16(16'(op_info_i))) begin
            if (op_info_i[OP_LUI]) begin
                enc_word  = {imm_i[31:12], rd_i, OPC_LUI};
                enc_legal = u_ok;
            end else if (op_info_i[OP_AUIPC]) begin
                enc_word  = {imm_i[31:12], rd_i, OPC_AUIPC};
                enc_legal = u_ok;
            end else if (op_info_i[OP_JAL]) begin
                enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
                enc_legal = j_ok;
            end else if (op_info_i[OP_JALR]) begin
                enc_word  = {imm_i[11:0], rs1_i, F3_JALR, rd_i, OPC_JALR};
                enc_legal = i_ok;
            end else if (op_info_i[OP_BRANCH]) begin
                enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, br_f3, imm_i[4:1], imm_i[11],
                             OPC_BRANCH};
                enc_legal = b_ok & is_onehot16(16'(br_fun_i));
            end else if (op_info_i[OP_LOAD]) begin
                enc_word  = {imm_i[11:0], rs1_i, ld_f3, rd_i, OPC_LOAD};
                enc_legal = i_ok & is_onehot16(16'(ld_fun_i));
            end else if (op_info_i[OP_STORE]) begin
                enc_word  = {imm_i[11:5], rs2_i, rs1_i, st_f3, imm_i[4:0], OPC_STORE};
                enc_legal = i_ok & is_onehot16(16'(st_fun_i));
            end else if (op_info_i[OP_ALU_I]) begin
                if (is_shift) begin
                    enc_word  = {alu_fun7_i, imm_i[4:0], rs1_i, alu_fun3_i, rd_i, OPC_ALU_I};
                    enc_legal = shamt_ok;
                end else begin
                    enc_word  = {imm_i[11:0], rs1_i, alu_fun3_i, rd_i, OPC_ALU_I};
                    enc_legal = i_ok;
                end
            end else if (op_info_i[OP_ALU_R]) begin
                enc_word  = {alu_fun7_i, rs2_i, rs1_i, alu_fun3_i, rd_i, OPC_ALU_R};
                enc_legal = 1'b1;
            end
        end
    end

    // Ready ignores out_ready_i: a full FIFO never takes a push, even alongside a pop.
    assign in_ready_o = ~fifo_full & ~rst;
    assign accept     = in_valid_i & in_ready_o;
    assign push       = accept & enc_legal;
    assign bad        = accept & ~enc_legal;

    always_comb begin
        err_d     = bad;
        err_cnt_d = err_cnt_q;
        if (bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'h1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'h0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;
    assign out_valid_o = ~fifo_empty;

    instr_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .wdata_i(enc_word),
        .full_o (fifo_full),
        .pop_i  (out_valid_o & out_ready_i),
        .rdata_o(out_instr_o),
        .empty_o(fifo_empty)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed table-driven bench for instr_encoder plus backpressure, saturation and reset sequences.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [8:0]  op_info_i = '0;
    logic [5:0]  br_fun_i = '0;
    logic [4:0]  ld_fun_i = '0;
    logic [2:0]  st_fun_i = '0;
    logic [2:0]  alu_fun3_i = '0;
    logic [6:0]  alu_fun7_i = '0;
    logic        ebreak_i = 1'b0;
    logic [4:0]  rs1_i = '0, rs2_i = '0, rd_i = '0;
    logic [63:0] imm_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_instr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    instr_encoder #(
        .XLEN (64),
        .DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .op_info_i  (op_info_i),
        .br_fun_i   (br_fun_i),
        .ld_fun_i   (ld_fun_i),
        .st_fun_i   (st_fun_i),
        .alu_fun3_i (alu_fun3_i),
        .alu_fun7_i (alu_fun7_i),
        .ebreak_i   (ebreak_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rd_i       (rd_i),
        .imm_i      (imm_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_instr_o(out_instr_o),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o)
    );

    localparam logic [8:0] O_LUI   = 9'(1) << OP_LUI;
    localparam logic [8:0] O_AUIPC = 9'(1) << OP_AUIPC;
    localparam logic [8:0] O_JAL   = 9'(1) << OP_JAL;
    localparam logic [8:0] O_JALR  = 9'(1) << OP_JALR;
    localparam logic [8:0] O_BR    = 9'(1) << OP_BRANCH;
    localparam logic [8:0] O_LD    = 9'(1) << OP_LOAD;
    localparam logic [8:0] O_ST    = 9'(1) << OP_STORE;
    localparam logic [8:0] O_ALUI  = 9'(1) << OP_ALU_I;
    localparam logic [8:0] O_ALUR  = 9'(1) << OP_ALU_R;

    typedef struct {
        string       name;
        logic [8:0]  op;
        logic [5:0]  br;
        logic [4:0]  ld;
        logic [2:0]  st;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        eb;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        legal;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [8:0] op, input logic [5:0] br,
                       input logic [4:0] ld, input logic [2:0] st, input logic [2:0] f3,
                       input logic [6:0] f7, input logic eb, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] imm,
                       input logic legal, input logic [31:0] instr);
        vec_t v;
        v.name = n; v.op = op; v.br = br; v.ld = ld; v.st = st; v.f3 = f3; v.f7 = f7;
        v.eb = eb; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
        v.legal = legal; v.instr = instr;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        op_info_i = v.op; br_fun_i = v.br; ld_fun_i = v.ld; st_fun_i = v.st;
        alu_fun3_i = v.f3; alu_fun7_i = v.f7; ebreak_i = v.eb;
        rs1_i = v.rs1; rs2_i = v.rs2; rd_i = v.rd; imm_i = v.imm;
    endtask

    // Single request into an empty FIFO with out_ready high.
    task automatic send(input vec_t v);
        @(negedge clk);
        drive(v);
        in_valid_i = 1'b1;
        #1;
        check({v.name, "_ready"}, 32'(in_ready_o), 32'd1);
        check({v.name, "_no_comb"}, 32'(out_valid_o), 32'd0);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        if (v.legal) begin
            check({v.name, "_valid"}, 32'(out_valid_o), 32'd1);
            check({v.name, "_instr"}, out_instr_o, v.instr);
            check({v.name, "_err"}, 32'(err_o), 32'd0);
        end else begin
            if (exp_cnt < 255) exp_cnt++;
            check({v.name, "_not_queued"}, 32'(out_valid_o), 32'd0);
            check({v.name, "_err_pulse"}, 32'(err_o), 32'd1);
        end
        check({v.name, "_err_cnt"}, 32'(err_cnt_o), 32'(exp_cnt));
        @(posedge clk);
        #1;
        check({v.name, "_drained"}, 32'(out_valid_o), 32'd0);
        check({v.name, "_err_low"}, 32'(err_o), 32'd0);
    endtask

    logic [31:0] words [5];

    initial begin
        vec_t w;

        add("addi_5",      O_ALUI, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0,  5'd1, 64'd5, 1, 32'h0050_0093);
        add("addi_ignore", O_ALUI, 0, 0, 0, 3'd0, 7'h7F, 0, 5'd0, 5'd31, 5'd1, 64'd5, 1, 32'h0050_0093);
        add("lui",         O_LUI,  0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0,  5'd2, 64'h1234_5000, 1,
            32'h1234_5137);
        add("sw",   O_ST, 0, 0, 3'b100, 3'd0, 7'h00, 0, 5'd1, 5'd2, 5'd0, 64'd4, 1, 32'h0020_A223);
        add("beq",  O_BR, 6'b000001, 0, 0, 3'd0, 7'h00, 0, 5'd1, 5'd2, 5'd0, 64'd8, 1, 32'h0020_8463);
        add("beq_odd", O_BR, 6'b000001, 0, 0, 3'd0, 7'h00, 0, 5'd1, 5'd2, 5'd0, 64'd3, 0, 32'h0);
        add("ebreak", 9'd0, 0, 0, 0, 3'd0, 7'h00, 1, 5'd0, 5'd0, 5'd0, 64'd0, 1, 32'h0010_0073);
        add("add",  O_ALUR, 0, 0, 0, 3'd0, 7'h00, 0, 5'd1, 5'd2, 5'd3, 64'd0, 1, 32'h0020_81B3);
        add("sub",  O_ALUR, 0, 0, 0, 3'd0, 7'h20, 0, 5'd1, 5'd2, 5'd3, 64'd0, 1, 32'h4020_81B3);
        add("srai", O_ALUI, 0, 0, 0, 3'd5, 7'h20, 0, 5'd6, 5'd0, 5'd5, 64'd3, 1, 32'h4033_5293);
        add("slli_big", O_ALUI, 0, 0, 0, 3'd1, 7'h00, 0, 5'd1, 5'd0, 5'd1, 64'd32, 0, 32'h0);
        add("addi_m1",  O_ALUI, 0, 0, 0, 3'd0, 7'h00, 0, 5'd1, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1,
            32'hFFF0_8093);
        add("addi_min", O_ALUI, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_F800, 1,
            32'h8000_0093);
        add("addi_over", O_ALUI, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd1, 64'd2048, 0, 32'h0);
        add("jal_m4", O_JAL, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1,
            32'hFFDF_F0EF);
        add("jal_over", O_JAL, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd1, 64'h0010_0000, 0, 32'h0);
        add("jal_odd",  O_JAL, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd1, 64'd5, 0, 32'h0);
        add("jalr", O_JALR, 0, 0, 0, 3'd0, 7'h00, 0, 5'd1, 5'd0, 5'd0, 64'd0, 1, 32'h0000_8067);
        add("lw",   O_LD, 0, 5'b00100, 0, 3'd0, 7'h00, 0, 5'd2, 5'd0, 5'd5, 64'd8, 1, 32'h0081_2283);
        add("lbu",  O_LD, 0, 5'b01000, 0, 3'd0, 7'h00, 0, 5'd1, 5'd0, 5'd1, 64'd0, 1, 32'h0000_C083);
        add("ld_twohot", O_LD, 0, 5'b00011, 0, 3'd0, 7'h00, 0, 5'd1, 5'd0, 5'd1, 64'd0, 0, 32'h0);
        add("st_none",   O_ST, 0, 0, 3'b000, 3'd0, 7'h00, 0, 5'd1, 5'd2, 5'd0, 64'd0, 0, 32'h0);
        add("br_twohot", O_BR, 6'b000011, 0, 0, 3'd0, 7'h00, 0, 5'd1, 5'd2, 5'd0, 64'd8, 0, 32'h0);
        add("blt_m8", O_BR, 6'b000100, 0, 0, 3'd0, 7'h00, 0, 5'd3, 5'd4, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8,
            1, 32'hFE41_CCE3);
        add("beq_min", O_BR, 6'b000001, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd0,
            64'hFFFF_FFFF_FFFF_F000, 1, 32'h8000_0063);
        add("beq_over", O_BR, 6'b000001, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd0, 64'd4096, 0, 32'h0);
        add("sb_m1", O_ST, 0, 0, 3'b001, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1,
            32'hFE00_0FA3);
        add("auipc_neg", O_AUIPC, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd10,
            64'hFFFF_FFFF_8000_0000, 1, 32'h8000_0517);
        add("lui_pos2g", O_LUI, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd2, 64'h0000_0000_8000_0000, 0,
            32'h0);
        add("lui_low",   O_LUI, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd2, 64'h1234_5678, 0, 32'h0);
        add("op_twohot", O_LUI | O_AUIPC, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd2, 64'h0, 0, 32'h0);
        add("op_zero",   9'd0, 0, 0, 0, 3'd0, 7'h00, 0, 5'd0, 5'd0, 5'd0, 64'h0, 0, 32'h0);
        add("ebreak_op", O_ALUR, 0, 0, 0, 3'd0, 7'h00, 1, 5'd0, 5'd0, 5'd0, 64'h0, 0, 32'h0);

        // Reset state
        #1;
        check("rst_ready", 32'(in_ready_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_instr", out_instr_o, 32'h0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) send(vecs[i]);

        // Backpressure: four accepts fill the FIFO, the fifth is refused.
        words[0] = 32'h0010_0093; words[1] = 32'h0020_0093; words[2] = 32'h0030_0093;
        words[3] = 32'h0040_0093; words[4] = 32'h0050_0093;
        w = vecs[0];
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ready", 32'(in_ready_o), 32'd1);
            if (i > 0) check("bp_head_stable", out_instr_o, words[0]);
            w.imm = 64'(i + 1);
            drive(w);
            in_valid_i = 1'b1;
        end
        @(negedge clk);
        check("bp_full", 32'(in_ready_o), 32'd0);
        w.imm = 64'd5;
        drive(w);
        @(posedge clk);
        #1;
        check("bp_still_full", 32'(in_ready_o), 32'd0);
        @(negedge clk);
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_drain_valid", 32'(out_valid_o), 32'd1);
            check("bp_drain_order", out_instr_o, words[k]);
            @(negedge clk);
        end
        check("bp_empty", 32'(out_valid_o), 32'd0);
        check("bp_ready_again", 32'(in_ready_o), 32'd1);

        // Error counter saturation
        @(negedge clk);
        drive(vecs[31]);
        in_valid_i = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        exp_cnt = 255;
        check("sat_err_cnt", 32'(err_cnt_o), 32'd255);
        check("sat_no_queue", 32'(out_valid_o), 32'd0);

        // Reset while three words are buffered
        out_ready_i = 1'b0;
        w = vecs[0];
        @(negedge clk);
        drive(w);
        in_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        check("pre_rst_valid", 32'(out_valid_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_ready", 32'(in_ready_o), 32'd0);
        check("mid_rst_instr", out_instr_o, 32'h0);
        check("mid_rst_err_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready_i = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready_o), 32'd1);
        check("post_rst_valid", 32'(out_valid_o), 32'd0);
        check("post_rst_err_cnt", 32'(err_cnt_o), 32'd0);
        exp_cnt = 0;
        send(vecs[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the RV32I instruction decoder: takes decoded fields and assembles the 32-bit RISC-V instruction word.
- Fields are op-class one-hot, sub-function one-hots, register numbers and a sign-extended immediate.
- Validates the request, then buffers legal words in a small FIFO with valid/ready on both sides.
- Used by the debug/program-buffer path and by self-checking benches to generate instruction streams for the single-cycle core.

Parameters:
XLEN, 64, width of imm_i; must be >= 32.
DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
in_valid_i  in  1  request valid.
in_ready_o  out  1  request accepted when in_valid_i & in_ready_o.
op_info_i  in  `OP_WIDTH  one-hot op class: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_I, ALU_R (bit indices from defines.v).
br_fun_i  in  `BR_FUN_WIDTH  one-hot BEQ/BNE/BLT/BGE/BLTU/BGEU.
ld_fun_i  in  `LD_FUN_WIDTH  one-hot LB/LH/LW/LBU/LHU.
st_fun_i  in  `ST_FUN_WIDTH  one-hot SB/SH/SW.
alu_fun3_i  in  3  funct3 for ALU_I/ALU_R.
alu_fun7_i  in  7  funct7 for ALU_R, and for ALU_I shifts (SLLI/SRLI/SRAI).
ebreak_i  in  1  encode EBREAK; op_info_i must be all-zero.
rs1_i, rs2_i, rd_i  in  5 each  register numbers.
imm_i  in  XLEN  sign-extended immediate, byte offset for B/J.
out_valid_o  out  1  out_instr_o valid.
out_ready_i  in  1  consumer ready.
out_instr_o  out  32  encoded instruction.
err_o  out  1  one-cycle pulse, cycle after an illegal request is accepted.
err_cnt_o  out  8  illegal requests accepted; saturates at 255.

Behaviour:
- Reset (asynchronous): FIFO empty, out_valid_o=0, out_instr_o=0, err_o=0, err_cnt_o=0.
  - in_ready_o=0 while rst is asserted; 1 after reset deasserts.
- Reset mid-operation flushes all buffered words. In-flight requests are lost.
- in_ready_o = !full. Readiness does not depend on out_ready_i, so a push is not allowed into a full FIFO even if a pop happens in the same cycle.
- Encoding is combinational on the input fields. Legal words are written into the FIFO on the accepting edge.
- Latency: with the FIFO empty, the word appears on out_instr_o with out_valid_o=1 on the cycle after acceptance. There is no combinational in->out path.
- out_instr_o holds the FIFO head and is stable while out_valid_o & !out_ready_i. It pops on out_valid_o & out_ready_i.
- Simultaneous push and pop when neither full nor empty: count is unchanged and order is preserved. Pointers wrap modulo DEPTH.
- Field placement:
  - rd in [11:7], rs1 in [19:15], rs2 in [24:20], funct3 in [14:12].
  - Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ALU_I 0010011, ALU_R 0110011.
  - funct3 values: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. LB 000, LH 001, LW 010, LBU 100, LHU 101. SB 000, SH 001, SW 010. JALR 000.
  - Immediate layouts are the standard I/S/B/U/J formats.
  - For ALU_I with funct3 001/101, [31:25]=alu_fun7_i and [24:20]=imm_i[4:0].
  - EBREAK = 0x00100073.
- Illegal request: accepted, not enqueued, err_o pulses next cycle, err_cnt_o increments. A request is illegal if any of:
  - op_info_i not one-hot and ebreak_i=0, or op_info_i nonzero with ebreak_i=1.
  - The sub-function for BRANCH/LOAD/STORE is not one-hot.
  - I/S immediate does not equal sign-extension of imm_i[11:0].
  - B immediate: imm_i[0]=1, or does not fit 13-bit signed.
  - J immediate: imm_i[0]=1, or does not fit 21-bit signed.
  - U immediate: imm_i[11:0]!=0, or does not equal sign-extension of imm_i[31:0].
  - ALU_I shift with imm_i[XLEN-1:5]!=0.
- Inputs that are don't-care for the selected format (e.g. rs2 for I-type) are ignored.

Decomposition:
- Opcode, funct3 and one-hot index constants live in defines.v, shared with the decoder. No new typedefs.
- One sub-module: instr_fifo, a generic synchronous FIFO parameterised by width and depth, with full/empty flags and async active-high reset.
- Encoding, legality check and error counter stay in instr_encoder.

Test Plan:
- ALU_I, fun3=000, rd=1, rs1=0, imm=5, out_ready=1 -> out_instr_o=0x00500093 one cycle after accept; err_o=0.
- LUI rd=2, imm=0x12345000 -> 0x12345137.
- STORE SW rs1=1, rs2=2, imm=4 -> 0x0020A223.
- BRANCH BEQ rs1=1, rs2=2, imm=8 -> 0x00208463.
- Same BEQ with imm=3 -> nothing enqueued; err_o pulses; err_cnt_o=1.
- ebreak_i=1 -> 0x00100073.
- Backpressure: out_ready=0, push DEPTH+1 legal words back-to-back -> in_ready_o drops after 4 accepts. Release out_ready -> 4 words drain in order, then in_ready_o=1.
- Assert rst while FIFO holds 3 words -> out_valid_o=0 immediately; after release FIFO is empty and err_cnt_o=0.
